// File: rtl/dlf_gearshift.sv
// rtl/dlf_gearshift.sv - bang-bang PLL loop filter with gear-shift acquisition controller
// Optional loss-of-lock re-acquisition is built when DLF_LOSS_OF_LOCK_EN is defined.
module dlf_gearshift #(
    parameter int ACC_WIDTH          = 10,
    parameter int GAIN_WIDTH         = 8,
    parameter int NUM_DITHERING_BITS = 5,
    parameter int NUM_GEARS          = 4,
    parameter int GEAR_CYCLES        = 64,
    parameter int LOL_RUN            = 16,
    localparam int GW = (NUM_GEARS > 1) ? $clog2(NUM_GEARS) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          updn,
    input  logic                          relock,
    input  logic [GAIN_WIDTH-1:0]         ki,
    input  logic [GAIN_WIDTH-1:0]         kp,
    output logic                          overflow,
    output logic                          underflow,
    output logic [NUM_DITHERING_BITS-1:0] ditherWidth,
    output logic [GW-1:0]                 gear,
    output logic                          locked
);
    localparam int DW = $clog2(GEAR_CYCLES);

    if (GAIN_WIDTH > ACC_WIDTH - 1) begin : g_bad_gain
        $error("GAIN_WIDTH must not exceed ACC_WIDTH-1");
    end
    if (NUM_DITHERING_BITS > ACC_WIDTH) begin : g_bad_dither
        $error("NUM_DITHERING_BITS must not exceed ACC_WIDTH");
    end
    if (NUM_GEARS < 2 || NUM_GEARS > 8) begin : g_bad_gears
        $error("NUM_GEARS must be in 2..8");
    end
    if (GEAR_CYCLES < 2 || LOL_RUN < 2) begin : g_bad_counts
        $error("GEAR_CYCLES and LOL_RUN must be at least 2");
    end

    typedef enum logic {S_ACQ, S_TRACK} state_t;

    state_t                  state_q, state_d;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic                    prev_q, prev_d;
    logic [GW-1:0]           gear_q, gear_d;
    logic [DW-1:0]           dwell_q, dwell_d;
    logic                    overflow_q, overflow_d;
    logic                    underflow_q, underflow_d;
    logic                    restart;
    logic [GAIN_WIDTH-1:0]   ki_eff, kp_eff;
    logic [ACC_WIDTH+1:0]    mag, sum;

    // Integral gain drops 4x per gear, proportional 2x per gear.
    assign ki_eff = ki >> {gear_q, 1'b0};
    assign kp_eff = kp >> gear_q;
    assign mag    = (ACC_WIDTH+2)'(ki_eff)
                  + ((updn != prev_q) ? (ACC_WIDTH+2)'(kp_eff) : '0);
    // Two's-complement sum: bit ACC+1 is the sign, bit ACC marks an upward wrap.
    assign sum    = {2'b00, acc_q} + (updn ? (~mag + 1'b1) : mag);

`ifdef DLF_LOSS_OF_LOCK_EN
    localparam int RW = $clog2(LOL_RUN + 1);
    logic [RW-1:0] run_q, run_d;
`endif

    always_comb begin
        acc_d       = acc_q;
        prev_d      = prev_q;
        gear_d      = gear_q;
        state_d     = state_q;
        dwell_d     = dwell_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        restart     = relock;
`ifdef DLF_LOSS_OF_LOCK_EN
        run_d       = run_q;
`endif
        if (enable) begin
            acc_d       = sum[ACC_WIDTH-1:0];
            underflow_d = sum[ACC_WIDTH+1];
            overflow_d  = ~sum[ACC_WIDTH+1] & sum[ACC_WIDTH];
            prev_d      = updn;
`ifdef DLF_LOSS_OF_LOCK_EN
            if (updn != prev_q) begin
                run_d = RW'(1);
            end else if (run_q != RW'(LOL_RUN)) begin
                run_d = run_q + 1'b1;
            end
            if (state_q == S_TRACK && run_d == RW'(LOL_RUN)) begin
                restart = 1'b1;
            end
`endif
            if (state_q == S_ACQ) begin
                if (dwell_q == DW'(GEAR_CYCLES - 1)) begin
                    dwell_d = '0;
                    gear_d  = gear_q + 1'b1;
                    if (gear_d == GW'(NUM_GEARS - 1)) begin
                        state_d = S_TRACK;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
        end
        // Restart overrides any dwell terminal count; acc and prev keep filtering.
        if (restart) begin
            gear_d  = '0;
            dwell_d = '0;
            state_d = S_ACQ;
`ifdef DLF_LOSS_OF_LOCK_EN
            run_d   = '0;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_ACQ;
            acc_q       <= '0;
            prev_q      <= 1'b0;
            gear_q      <= '0;
            dwell_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
`ifdef DLF_LOSS_OF_LOCK_EN
            run_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            prev_q      <= prev_d;
            gear_q      <= gear_d;
            dwell_q     <= dwell_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
`ifdef DLF_LOSS_OF_LOCK_EN
            run_q       <= run_d;
`endif
        end
    end

    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign ditherWidth = acc_q[ACC_WIDTH-1 -: NUM_DITHERING_BITS];
    assign gear        = gear_q;
    assign locked      = (state_q == S_TRACK);

endmodule

// File: tb/tb_dlf_gearshift.sv
// tb/tb_dlf_gearshift.sv - self-checking bench for dlf_gearshift
// Reference model works on integer accumulator value and an enabled-sample count since acquisition start.
module tb_dlf_gearshift;
    localparam int AW = 10;
    localparam int GC = 64;
    localparam int NG = 4;
    localparam int LR = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       updn = 1'b0;
    logic       relock = 1'b0;
    logic [7:0] ki = '0;
    logic [7:0] kp = '0;
    logic       overflow, underflow, locked;
    logic [4:0] ditherWidth;
    logic [1:0] gear;

    dlf_gearshift dut (
        .clock(clock), .reset(reset), .enable(enable), .updn(updn), .relock(relock),
        .ki(ki), .kp(kp), .overflow(overflow), .underflow(underflow),
        .ditherWidth(ditherWidth), .gear(gear), .locked(locked)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int m_acc, m_prev, m_cnt, m_run, m_ovf, m_udf;

    typedef struct {
        logic en;
        logic ud;
        int   exp_ovf;
        int   exp_udf;
        int   exp_dw;
    } vec_t;
    vec_t vecs[8];

    function automatic int m_gear();
        return (m_cnt / GC > NG - 1) ? NG - 1 : m_cnt / GC;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".overflow"}, overflow, m_ovf);
        check({tag, ".underflow"}, underflow, m_udf);
        check({tag, ".dither"}, ditherWidth, m_acc / 32);
        check({tag, ".gear"}, gear, m_gear());
        check({tag, ".locked"}, locked, (m_gear() == NG - 1) ? 1 : 0);
    endtask

    task automatic model_reset();
        m_acc = 0; m_prev = 0; m_cnt = 0; m_run = 0; m_ovf = 0; m_udf = 0;
    endtask

    task automatic model_step();
        int g, kie, kpe, mag, s, lol;
        g = m_gear();
        lol = 0;
        m_ovf = 0;
        m_udf = 0;
        if (enable) begin
            kie = int'(ki) >> (2 * g);
            kpe = int'(kp) >> g;
            mag = kie + ((int'(updn) != m_prev) ? kpe : 0);
            s = updn ? m_acc - mag : m_acc + mag;
            m_ovf = (s >= (1 << AW)) ? 1 : 0;
            m_udf = (s < 0) ? 1 : 0;
            m_acc = (s + (1 << AW)) % (1 << AW);
            m_run = (int'(updn) == m_prev) ? m_run + 1 : 1;
`ifdef DLF_LOSS_OF_LOCK_EN
            lol = (g == NG - 1 && m_run >= LR) ? 1 : 0;
`endif
            m_prev = int'(updn);
            if (g < NG - 1) m_cnt++;
        end
        if (relock || lol != 0) begin
            m_cnt = 0;
            m_run = 0;
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        #1;
        reset = 1'b1;
        enable = 1'b0; updn = 1'b0; relock = 1'b0;
    endtask

    initial begin
        #1;
        do_reset();

        // Alternating transitions with ki=0 wrap the accumulator down then up.
        vecs[0] = '{1'b1, 1'b1, 0, 1, 31};
        vecs[1] = '{1'b1, 1'b0, 1, 0, 0};
        vecs[2] = '{1'b1, 1'b1, 0, 1, 31};
        vecs[3] = '{1'b1, 1'b0, 1, 0, 0};
        vecs[4] = '{1'b0, 1'b1, 0, 0, 0};
        vecs[5] = '{1'b1, 1'b1, 0, 1, 31};
        vecs[6] = '{1'b1, 1'b1, 0, 0, 31};
        vecs[7] = '{1'b1, 1'b0, 1, 0, 0};
        ki = 8'd0; kp = 8'd16;
        for (int i = 0; i < 8; i++) begin
            enable = vecs[i].en;
            updn   = vecs[i].ud;
            tick("vec");
            check($sformatf("vec%0d.ovf", i), overflow, vecs[i].exp_ovf);
            check($sformatf("vec%0d.udf", i), underflow, vecs[i].exp_udf);
            check($sformatf("vec%0d.dw", i), ditherWidth, vecs[i].exp_dw);
        end

        // Constant ramp of 4 per edge; periodic relock keeps gear 0 without touching acc.
        do_reset();
        ki = 8'd4; kp = 8'd16; enable = 1'b1; updn = 1'b0;
        for (int e = 1; e <= 256; e++) begin
            relock = (e % 50 == 0);
            tick("ramp");
            if (e == 8)   check("ramp.e8.dw", ditherWidth, 1);
            if (e == 255) check("ramp.e255.ovf", overflow, 0);
            if (e == 255) check("ramp.e255.dw", ditherWidth, 31);
            if (e == 256) check("ramp.e256.ovf", overflow, 1);
            if (e == 256) check("ramp.e256.dw", ditherWidth, 0);
        end
        relock = 1'b0;

        // Gear schedule from reset, then gear-3 gains with ki=64, kp=128.
        do_reset();
        enable = 1'b1;
        ki = 8'($urandom); kp = 8'($urandom);
        for (int e = 1; e <= 192; e++) begin
            updn = 1'($urandom);
            tick("sched");
            if (e == 63)  check("sched.e63.gear", gear, 0);
            if (e == 64)  check("sched.e64.gear", gear, 1);
            if (e == 128) check("sched.e128.gear", gear, 2);
            if (e == 191) check("sched.e191.locked", locked, 0);
            if (e == 192) check("sched.e192.gear", gear, 3);
            if (e == 192) check("sched.e192.locked", locked, 1);
        end
        ki = 8'd64; kp = 8'd128;
        for (int e = 0; e < 120; e++) begin
            updn = (e % 3 == 0);
            tick("gear3");
        end

        // Enable held low mid-acquisition freezes everything.
        do_reset();
        ki = 8'd37; kp = 8'd90; enable = 1'b1;
        for (int e = 0; e < 30; e++) begin updn = 1'($urandom); tick("frz_a"); end
        enable = 1'b0;
        for (int e = 0; e < 10; e++) begin
            updn = 1'($urandom);
            tick("frz_off");
            check("frz.ovf", overflow, 0);
            check("frz.udf", underflow, 0);
        end
        enable = 1'b1;
        for (int e = 31; e <= 64; e++) begin
            updn = 1'($urandom);
            tick("frz_b");
            if (e == 63) check("frz.e63.gear", gear, 0);
            if (e == 64) check("frz.e64.gear", gear, 1);
        end

        // Relock on the dwell terminal edge wins over the gear increment.
        do_reset();
        ki = 8'd10; kp = 8'd20; enable = 1'b1;
        for (int e = 1; e <= 64; e++) begin
            updn = 1'($urandom);
            relock = (e == 64);
            tick("rlk");
        end
        check("rlk.e64.gear", gear, 0);
        relock = 1'b0;
        for (int e = 1; e <= 64; e++) begin
            updn = 1'($urandom);
            tick("rlk2");
            if (e == 63) check("rlk.after63.gear", gear, 0);
            if (e == 64) check("rlk.after64.gear", gear, 1);
        end

        // Lock with alternating decisions, then a run of 16 identical samples.
        do_reset();
        ki = 8'd8; kp = 8'd8; enable = 1'b1;
        for (int e = 0; e < 192; e++) begin
            updn = 1'((e + 1) % 2);
            tick("lol_acq");
        end
        check("lol.locked_before", locked, 1);
        updn = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick("lol_run");
            if (e == 15) check("lol.e15.locked", locked, 1);
        end
`ifdef DLF_LOSS_OF_LOCK_EN
        check("lol.e16.locked", locked, 0);
        check("lol.e16.gear", gear, 0);
`else
        check("lol.e16.locked", locked, 1);
        check("lol.e16.gear", gear, 3);
`endif

        // Randomized soak with sticky updn so long runs and wraps occur.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 256 == 0) begin ki = 8'($urandom); kp = 8'($urandom); end
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) updn = ~updn;
            relock = ($urandom_range(0, 199) == 0);
            if (c == 1500) do_reset();
            else tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
